// File: rtl/pto_ramp_gen_if.sv
// Control, motion-profile and status signals shared between the PTO register
// block (master) and the ramp generator core (slave).
interface pto_ramp_gen_if #(
    parameter int W = 32
);
    logic         start;
    logic         abort;
    logic [W-1:0] pulse_start;
    logic [W-1:0] pulse_stop;
    logic [W-1:0] pulse_end;
    logic [W-1:0] period_max_us;
    logic [W-1:0] period_min_us;
    logic [W-1:0] step;
    logic [W-1:0] T_hold_us;
    logic         pto_out;
    logic         busy;
    logic         program_end;
    logic         cfg_err;
    logic [W-1:0] pulse_count;

    modport master (
        output start, abort, pulse_start, pulse_stop, pulse_end,
               period_max_us, period_min_us, step, T_hold_us,
        input  pto_out, busy, program_end, cfg_err, pulse_count
    );

    modport slave (
        input  start, abort, pulse_start, pulse_stop, pulse_end,
               period_max_us, period_min_us, step, T_hold_us,
        output pto_out, busy, program_end, cfg_err, pulse_count
    );
endinterface

// File: rtl/pto_ramp_gen.sv
// Trapezoidal-velocity step pulse generator: accelerates from period_max_us down
// to period_min_us, cruises, decelerates back, then dwells before completion.
module pto_ramp_gen #(
    parameter int CLKS_PER_US = 50,
    parameter int W           = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    pto_ramp_gen_if.slave bus
);
    localparam int            PW         = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_US - 1);

    typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, HOLD, DONE} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc;
    logic          tick, accept, valid;
    logic [W-1:0]  lat_start, lat_stop, lat_end, lat_max, lat_min, lat_step, lat_hold;
    logic [W-1:0]  cur_period, period_nxt;
    logic [W-1:0]  tick_cnt, tick_nxt;
    logic [W-1:0]  count, count_nxt;
    logic [W:0]    decel_sum;
    logic          cfg_q, cfg_nxt;
    logic          pto_q, pto_nxt;
    logic          busy_q, busy_nxt;
    logic          end_q, end_nxt;

    function automatic state_t phase_of(input logic [W-1:0] k, input logic [W-1:0] s,
                                        input logic [W-1:0] p, input logic [W-1:0] e);
        state_t ph;
        if (k < s)      ph = ACCEL;
        else if (k < p) ph = CRUISE;
        else if (k < e) ph = DECEL;
        else            ph = HOLD;
        return ph;
    endfunction

    assign tick   = (presc == PRESC_LAST);
    assign accept = bus.start && ((state == IDLE) || (state == DONE));
    assign valid  = (bus.pulse_start <= bus.pulse_stop) && (bus.pulse_stop <= bus.pulse_end) &&
                    (bus.period_min_us >= W'(2)) && (bus.period_min_us <= bus.period_max_us) &&
                    ((bus.step != '0) ||
                     ((bus.pulse_start == bus.pulse_stop) && (bus.pulse_stop == bus.pulse_end)));
    assign decel_sum = {1'b0, cur_period} + {1'b0, lat_step};

    // Restarting the prescaler on accept aligns the first us tick to the run start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           presc <= '0;
        else if (accept || tick) presc <= '0;
        else                    presc <= presc + PW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_start <= '0;
            lat_stop  <= '0;
            lat_end   <= '0;
            lat_max   <= '0;
            lat_min   <= '0;
            lat_step  <= '0;
            lat_hold  <= '0;
        end else if (accept) begin
            lat_start <= bus.pulse_start;
            lat_stop  <= bus.pulse_stop;
            lat_end   <= bus.pulse_end;
            lat_max   <= bus.period_max_us;
            lat_min   <= bus.period_min_us;
            lat_step  <= bus.step;
            lat_hold  <= bus.T_hold_us;
        end
    end

    always_comb begin
        state_nxt  = state;
        period_nxt = cur_period;
        tick_nxt   = tick_cnt;
        count_nxt  = count;
        cfg_nxt    = cfg_q;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    count_nxt  = '0;
                    cfg_nxt    = 1'b0;
                    period_nxt = bus.period_max_us;
                    tick_nxt   = '0;
                    if (!valid) begin
                        state_nxt = DONE;
                        cfg_nxt   = 1'b1;
                    end else begin
                        state_nxt = phase_of('0, bus.pulse_start, bus.pulse_stop, bus.pulse_end);
                    end
                end
            end
            ACCEL, CRUISE, DECEL: begin
                if (bus.abort) begin
                    state_nxt = DONE;
                end else if (tick) begin
                    if (tick_cnt == cur_period - W'(1)) begin
                        tick_nxt  = '0;
                        count_nxt = count + W'(1);
                        // cur_period never drops below lat_min, so the subtraction is safe.
                        if (state == ACCEL)
                            period_nxt = (cur_period - lat_min <= lat_step) ? lat_min
                                                                          : cur_period - lat_step;
                        else if (state == DECEL)
                            period_nxt = (decel_sum > {1'b0, lat_max}) ? lat_max : decel_sum[W-1:0];
                        state_nxt = phase_of(count + W'(1), lat_start, lat_stop, lat_end);
                    end else begin
                        tick_nxt = tick_cnt + W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.abort || (lat_hold == '0)) begin
                    state_nxt = DONE;
                end else if (tick) begin
                    if (tick_cnt == lat_hold - W'(1)) state_nxt = DONE;
                    else                              tick_nxt  = tick_cnt + W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = state_nxt inside {ACCEL, CRUISE, DECEL, HOLD};
        end_nxt  = (state_nxt == DONE);
        pto_nxt  = (state_nxt inside {ACCEL, CRUISE, DECEL}) && (tick_nxt < (period_nxt >> 1));
    end

    // Outputs are registered from next-state values so pto_out is glitch-free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur_period <= '0;
            tick_cnt   <= '0;
            count      <= '0;
            cfg_q      <= 1'b0;
            pto_q      <= 1'b0;
            busy_q     <= 1'b0;
            end_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_period <= period_nxt;
            tick_cnt   <= tick_nxt;
            count      <= count_nxt;
            cfg_q      <= cfg_nxt;
            pto_q      <= pto_nxt;
            busy_q     <= busy_nxt;
            end_q      <= end_nxt;
        end
    end

    assign bus.pto_out     = pto_q;
    assign bus.busy        = busy_q;
    assign bus.program_end = end_q;
    assign bus.cfg_err     = cfg_q;
    assign bus.pulse_count = count;
endmodule
